// File: rtl/dmem_ctrl_if.sv
// Core <-> data-memory controller bus: request struct plus byte address in,
// response struct plus busy flag out, with valid/yumi handshakes on both sides.
interface dmem_ctrl_if;
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  mem_in_s     to_mem_i;
  logic [31:0] addr_i;
  mem_out_s    from_mem_o;
  logic        busy_o;

  modport master (output to_mem_i, addr_i, input  from_mem_o, busy_o);
  modport slave  (input  to_mem_i, addr_i, output from_mem_o, busy_o);
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store, performs it against an internal
// word RAM after latency_p cycles, and holds the response until the core yumis it.
module dmem_ctrl #(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t r_state, w_next;

  logic [3:0]              r_cnt;
  logic [addr_width_p-1:0] r_idx;
  logic [1:0]              r_lane;
  logic [31:0]             r_wdata;
  logic                    r_wen;
  logic                    r_bnw;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [2**addr_width_p];

  logic                    w_accept;
  logic                    w_access;
  logic [addr_width_p-1:0] w_idx;
  logic [1:0]              w_lane;
  logic [31:0]             w_wdata;
  logic                    w_wen;
  logic                    w_bnw;
  logic [31:0]             w_old;
  logic [31:0]             w_new;
  logic [31:0]             w_load;

  assign w_accept = (r_state == IDLE) && bus.to_mem_i.valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (latency_p == 1) ? RESP : BUSY;
      BUSY: if (r_cnt == 4'd1) w_next = RESP;
      RESP: if (bus.to_mem_i.yumi) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With latency_p == 1 the access happens on the accept edge, before the
  // request fields are latched, so the access path reads the live inputs in IDLE.
  always_comb begin
    if (r_state == IDLE) begin
      w_idx   = bus.addr_i[addr_width_p+1:2];
      w_lane  = bus.addr_i[1:0];
      w_wdata = bus.to_mem_i.write_data;
      w_wen   = bus.to_mem_i.wen;
      w_bnw   = bus.to_mem_i.byte_not_word;
    end else begin
      w_idx   = r_idx;
      w_lane  = r_lane;
      w_wdata = r_wdata;
      w_wen   = r_wen;
      w_bnw   = r_bnw;
    end
  end

  assign w_access = !reset && (w_next == RESP) && (r_state != RESP);
  assign w_old    = r_mem[w_idx];

  always_comb begin
    w_new  = w_wdata;
    w_load = w_old;
    if (w_bnw) begin
      w_new                         = w_old;
      w_new[{w_lane, 3'b000} +: 8]  = w_wdata[7:0];
      w_load                        = '0;
      w_load[7:0]                   = w_old[{w_lane, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_access && w_wen) r_mem[w_idx] <= w_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_bnw   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(latency_p - 1);
        r_idx   <= bus.addr_i[addr_width_p+1:2];
        r_lane  <= bus.addr_i[1:0];
        r_wdata <= bus.to_mem_i.write_data;
        r_wen   <= bus.to_mem_i.wen;
        r_bnw   <= bus.to_mem_i.byte_not_word;
      end else if (r_state == BUSY) begin
        r_cnt   <= r_cnt - 4'd1;
      end
      // Stores return the full pre-write word; loads return the selected data.
      if (w_access) r_rdata <= w_wen ? w_old : w_load;
    end
  end

  always_comb begin
    bus.from_mem_o.read_data = r_rdata;
    bus.from_mem_o.valid     = (r_state == RESP);
    bus.from_mem_o.yumi      = w_accept;
    bus.busy_o               = (r_state != IDLE);
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus randomized checks of dmem_ctrl at latency 2 and latency 1
// against a word-array reference model of the memory.
module tb_dmem_ctrl;

  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if bus_a ();
  dmem_ctrl_if bus_b ();

  dmem_ctrl #(.addr_width_p(10), .latency_p(LAT_A)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  dmem_ctrl #(.addr_width_p(10), .latency_p(1))     u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  logic [31:0] exp_rd;
  bit          exp_known;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_op(int d, bit wen, bit bnw, logic [31:0] a, logic [31:0] wd);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] old;
    idx = (a >> 2) % 1024;
    sh  = (a % 4) * 8;
    old = m_mem[d][idx];
    exp_known = m_known[d][idx];
    if (wen) begin
      exp_rd = old;
      if (bnw) m_mem[d][idx] = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      else begin
        m_mem[d][idx]   = wd;
        m_known[d][idx] = 1'b1;
      end
    end else begin
      exp_rd = bnw ? ((old >> sh) & 32'hFF) : old;
    end
  endtask

  task automatic issue(bit wen, bit bnw, logic [31:0] a, logic [31:0] wd, bit upd);
    @(negedge clk);
    bus_a.to_mem_i.write_data    = wd;
    bus_a.to_mem_i.wen           = wen;
    bus_a.to_mem_i.byte_not_word = bnw;
    bus_a.to_mem_i.yumi          = 1'b0;
    bus_a.to_mem_i.valid         = 1'b1;
    bus_a.addr_i                 = a;
    #1;
    chk("accept_yumi", 32'(bus_a.from_mem_o.yumi), 1);
    chk("accept_busy", 32'(bus_a.busy_o), 0);
    @(posedge clk);
    #1;
    if (upd) model_op(0, wen, bnw, a, wd);
    chk("post_accept_busy", 32'(bus_a.busy_o), 1);
    chk("no_reaccept_busy", 32'(bus_a.from_mem_o.yumi), 0);
  endtask

  task automatic complete(int hold, bit keep, bit reaccept);
    if (!keep) bus_a.to_mem_i.valid = 1'b0;
    for (int k = 1; k < LAT_A; k++) begin
      chk("lat_valid_low", 32'(bus_a.from_mem_o.valid), 0);
      @(posedge clk);
      #1;
    end
    chk("resp_valid", 32'(bus_a.from_mem_o.valid), 1);
    if (exp_known) chk("resp_data", bus_a.from_mem_o.read_data, exp_rd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus_a.from_mem_o.valid), 1);
      if (exp_known) chk("hold_data", bus_a.from_mem_o.read_data, exp_rd);
      chk("hold_no_accept", 32'(bus_a.from_mem_o.yumi), 0);
    end
    @(negedge clk);
    bus_a.to_mem_i.yumi = 1'b1;
    if (!reaccept) bus_a.to_mem_i.valid = 1'b0;
    #1;
    chk("resp_yumi_o_low", 32'(bus_a.from_mem_o.yumi), 0);
    @(posedge clk);
    #1;
    bus_a.to_mem_i.yumi = 1'b0;
    chk("idle_valid", 32'(bus_a.from_mem_o.valid), 0);
    chk("idle_busy", 32'(bus_a.busy_o), 0);
    if (reaccept) chk("reaccept_yumi", 32'(bus_a.from_mem_o.yumi), 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    bit          wen;
    bit          bnw;

    bus_a.to_mem_i = '0;
    bus_a.addr_i   = '0;
    bus_b.to_mem_i = '0;
    bus_b.addr_i   = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus_a.from_mem_o.valid), 0);
    chk("rst_yumi", 32'(bus_a.from_mem_o.yumi), 0);
    chk("rst_busy", 32'(bus_a.busy_o), 0);
    chk("rst_rdata", bus_a.from_mem_o.read_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // Give the first 16 words known contents; word 8 (byte 0x20) holds zero.
    for (int i = 0; i < 16; i++) begin
      wd = (i == 8) ? 32'h0 : $urandom;
      issue(1'b1, 1'b0, 32'(i * 4), wd, 1'b1);
      complete(0, 1'b0, 1'b0);
    end

    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
    complete(0, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    chk("tp_load_model", exp_rd, 32'hDEADBEEF);
    complete(0, 1'b0, 1'b0);

    issue(1'b1, 1'b0, 32'h10, 32'h11223344, 1'b1);
    complete(0, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 32'h13, 32'hFFFFFF5A, 1'b1);
    complete(1, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    chk("tp_byte_merge_model", exp_rd, 32'h5A223344);
    complete(0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 32'h13, 32'h0, 1'b1);
    chk("tp_byte_load_model", exp_rd, 32'h0000005A);
    complete(0, 1'b0, 1'b0);

    // Backpressure: request held high through RESP, accepted only after yumi.
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    complete(5, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    model_op(0, 1'b0, 1'b0, 32'h10, 32'h0);
    chk("reaccept_busy", 32'(bus_a.busy_o), 1);
    complete(0, 1'b0, 1'b0);

    issue(1'b1, 1'b0, 32'h1000, 32'hCAFE0001, 1'b1);
    complete(0, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 32'h0000, 32'h0, 1'b1);
    chk("tp_wrap_model", exp_rd, 32'hCAFE0001);
    complete(0, 1'b0, 1'b0);

    // Reset while the store is still in BUSY: nothing may be committed.
    issue(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus_a.to_mem_i.valid = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus_a.from_mem_o.valid), 0);
    chk("midrst_yumi", 32'(bus_a.from_mem_o.yumi), 0);
    chk("midrst_busy", 32'(bus_a.busy_o), 0);
    chk("midrst_rdata", bus_a.from_mem_o.read_data, 0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 1'b0, 32'h20, 32'h0, 1'b1);
    chk("tp_dropped_model", exp_rd, 32'h0);
    complete(0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      wd  = $urandom;
      wen = 1'($urandom_range(0, 1));
      bnw = 1'($urandom_range(0, 1));
      issue(wen, bnw, a, wd, 1'b1);
      complete($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Latency 1: valid and core yumi held high, one transaction every 2 cycles.
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      wen = (j < 4);
      bnw = (j >= 4) && j[0];
      a   = ($urandom & 32'hFFFF_F000) | 32'((j % 4) * 4) | 32'($urandom_range(0, 3));
      wd  = $urandom;
      bus_b.to_mem_i.write_data    = wd;
      bus_b.to_mem_i.wen           = wen;
      bus_b.to_mem_i.byte_not_word = bnw;
      bus_b.to_mem_i.valid         = 1'b1;
      bus_b.to_mem_i.yumi          = 1'b1;
      bus_b.addr_i                 = a;
      model_op(1, wen, bnw, a, wd);
      #1;
      chk("l1_accept_yumi", 32'(bus_b.from_mem_o.yumi), 1);
      chk("l1_accept_valid", 32'(bus_b.from_mem_o.valid), 0);
      @(negedge clk);
      #1;
      chk("l1_resp_valid", 32'(bus_b.from_mem_o.valid), 1);
      chk("l1_resp_yumi", 32'(bus_b.from_mem_o.yumi), 0);
      if (exp_known) chk("l1_resp_data", bus_b.from_mem_o.read_data, exp_rd);
    end
    @(negedge clk);
    bus_b.to_mem_i.valid = 1'b0;
    bus_b.to_mem_i.yumi  = 1'b0;
    #1;
    chk("l1_idle_busy", 32'(bus_b.busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
